// File: rtl/pending_priority_encoder_pkg.sv
// Shared definitions for the pending priority encoder and its pick helper:
// priority mode constants, output slot state encoding and a clog2 helper.
package pending_priority_encoder_pkg;

   // Priority mode values for the MSB_FIRST parameter
   localparam bit MSB_FIRST_MODE = 1'b1;
   localparam bit LSB_FIRST_MODE = 1'b0;

   // Output slot state: EMPTY holds nothing, FULL holds an unconsumed index
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Ceiling log2, usable in parameter/localparam expressions
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pending_priority_encoder_pick.sv
// Purely combinational priority select over a pending vector. Returns the
// winning index, its one-hot mask and whether any bit is set. Kept free of
// state so later arbiters can reuse it.
module priority_pick
   import pending_priority_encoder_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = MSB_FIRST_MODE,
   localparam int W        = clog2(N)
) (
   input  logic [N-1:0] pending,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot,
   output logic         any
);

   // Scan in rising or falling order so the last set bit seen is the winner
   always_comb begin
      idx    = '0;
      any    = 1'b0;
      onehot = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
               idx = W'(i);
               any = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
               idx = W'(i);
               any = 1'b1;
            end
         end
      end
      for (int j = 0; j < N; j++) begin
         onehot[j] = any && (W'(j) == idx);
      end
   end

endmodule

// File: rtl/pending_priority_encoder.sv
// Registered request front end: request pulses set sticky pending bits, the
// highest-priority pending line is issued through a one-entry valid/ready
// slot and cleared from pending, and duplicate requests raise overflow.
//
// Handshake: out_valid=1 means out_idx holds an unconsumed index; an index is
// consumed at a clk edge where out_valid & out_ready. While out_valid is high
// and out_ready is low, out_idx and out_valid do not change. out_valid is a
// direct decode of the slot FSM state, so it doubles as its debug view.
module pending_priority_encoder
   import pending_priority_encoder_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = MSB_FIRST_MODE,
   localparam int W        = clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   output logic [N-1:0] pending,
   output logic         overflow
);

   slot_state_e  state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] out_idx_q, out_idx_d;
   logic         overflow_q, overflow_d;

   logic [W-1:0] pick_idx;
   logic [N-1:0] pick_onehot;
   logic         pick_any;
   logic         slot_free;
   logic         issue;
   logic [N-1:0] clear_mask;

   // Pick only looks at registered pending bits; req_in never bypasses
   priority_pick #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_pick (
      .pending (pending_q),
      .idx     (pick_idx),
      .onehot  (pick_onehot),
      .any     (pick_any)
   );

   // Slot state register, async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Slot next state: refill whenever the slot frees, go empty if nothing pends
   always_comb begin
      state_d = state_q;
      if (slot_free) begin
         state_d = pick_any ? SLOT_FULL : SLOT_EMPTY;
      end
   end

   // Slot outputs
   always_comb begin
      out_valid = (state_q == SLOT_FULL);
   end

   // Issue decision, pending/overflow/index next values; set wins over clear
   always_comb begin
      slot_free  = (state_q == SLOT_EMPTY) || out_ready;
      issue      = slot_free && pick_any;
      clear_mask = issue ? pick_onehot : '0;
      pending_d  = (pending_q & ~clear_mask) | req_in;
      overflow_d = |(req_in & pending_q & ~clear_mask);
      out_idx_d  = issue ? pick_idx : out_idx_q;
   end

   // Datapath registers, async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q  <= '0;
         out_idx_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         out_idx_q  <= out_idx_d;
         overflow_q <= overflow_d;
      end
   end

   assign out_idx  = out_idx_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed bench for pending_priority_encoder: one MSB-first and one
// LSB-first instance sharing a clock, hand-computed expectations.
module tb_pending_priority_encoder;

   logic       clk;
   logic       rst;
   logic [7:0] req_in;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_valid;
   logic [7:0] pending;
   logic       overflow;

   logic [7:0] req_in_l;
   logic       out_ready_l;
   logic [2:0] out_idx_l;
   logic       out_valid_l;
   logic [7:0] pending_l;
   logic       overflow_l;

   int n_cmp;
   int n_err;

   pending_priority_encoder #(.N(8), .MSB_FIRST(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .pending   (pending),
      .overflow  (overflow)
   );

   pending_priority_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in_l),
      .out_ready (out_ready_l),
      .out_idx   (out_idx_l),
      .out_valid (out_valid_l),
      .pending   (pending_l),
      .overflow  (overflow_l)
   );

   // Clock: 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic v, input logic [2:0] idx,
                           input logic [7:0] pend, input logic ovf);
      chk({tag, "_valid"}, 64'(out_valid), 64'(v));
      if (v) chk({tag, "_idx"}, 64'(out_idx), 64'(idx));
      chk({tag, "_pending"}, 64'(pending), 64'(pend));
      chk({tag, "_overflow"}, 64'(overflow), 64'(ovf));
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      req_in      = '0;
      out_ready   = 1'b1;
      req_in_l    = '0;
      out_ready_l = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      rst = 1'b0;
      tick();

      // 1: one-hot requests, each issued two edges later for one cycle
      for (int k = 7; k >= 0; k--) begin
         req_in = 8'(1 << k);
         tick();
         chk_main("t1_capture", 1'b0, 3'd0, 8'(1 << k), 1'b0);
         req_in = '0;
         tick();
         chk_main("t1_issue", 1'b1, 3'(k), 8'h00, 1'b0);
         tick();
         chk_main("t1_drain", 1'b0, 3'd0, 8'h00, 1'b0);
      end

      // 2: three lines at once, ready high -> 7,5,2 back to back
      req_in = 8'b10100100;
      tick();
      chk_main("t2_capture", 1'b0, 3'd0, 8'hA4, 1'b0);
      req_in = '0;
      tick();
      chk_main("t2_i7", 1'b1, 3'd7, 8'h24, 1'b0);
      tick();
      chk_main("t2_i5", 1'b1, 3'd5, 8'h04, 1'b0);
      tick();
      chk_main("t2_i2", 1'b1, 3'd2, 8'h00, 1'b0);
      tick();
      chk_main("t2_empty", 1'b0, 3'd0, 8'h00, 1'b0);

      // 3: same burst with ready low for 5 cycles -> 7 held
      out_ready = 1'b0;
      req_in = 8'b10100100;
      tick();
      chk_main("t3_capture", 1'b0, 3'd0, 8'hA4, 1'b0);
      req_in = '0;
      tick();
      chk_main("t3_hold0", 1'b1, 3'd7, 8'h24, 1'b0);
      for (int c = 1; c < 5; c++) begin
         tick();
         chk_main("t3_hold", 1'b1, 3'd7, 8'h24, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      chk_main("t3_i5", 1'b1, 3'd5, 8'h04, 1'b0);
      tick();
      chk_main("t3_i2", 1'b1, 3'd2, 8'h00, 1'b0);
      tick();
      chk_main("t3_empty", 1'b0, 3'd0, 8'h00, 1'b0);

      // 4: slot holds line 6, line 3 requested twice -> one overflow pulse
      out_ready = 1'b0;
      req_in = 8'h40;
      tick();
      chk_main("t4_cap6", 1'b0, 3'd0, 8'h40, 1'b0);
      req_in = '0;
      tick();
      chk_main("t4_hold6", 1'b1, 3'd6, 8'h00, 1'b0);
      req_in = 8'h08;
      tick();
      chk_main("t4_first3", 1'b1, 3'd6, 8'h08, 1'b0);
      req_in = '0;
      tick();
      chk_main("t4_gap", 1'b1, 3'd6, 8'h08, 1'b0);
      req_in = 8'h08;
      tick();
      chk_main("t4_dup3", 1'b1, 3'd6, 8'h08, 1'b1);
      req_in = '0;
      tick();
      chk_main("t4_pulse_end", 1'b1, 3'd6, 8'h08, 1'b0);
      // request on the held line is a new event, not an overflow
      req_in = 8'h40;
      tick();
      chk_main("t4_req_held", 1'b1, 3'd6, 8'h48, 1'b0);
      req_in = '0;
      out_ready = 1'b1;
      tick();
      chk_main("t4_i6", 1'b1, 3'd6, 8'h08, 1'b0);
      tick();
      chk_main("t4_i3", 1'b1, 3'd3, 8'h00, 1'b0);
      tick();
      chk_main("t4_empty", 1'b0, 3'd0, 8'h00, 1'b0);

      // 5: LSB-first instance -> 2,5,7
      req_in_l = 8'b10100100;
      tick();
      chk("t5_capture", 64'(pending_l), 64'hA4);
      chk("t5_capture_valid", 64'(out_valid_l), 64'd0);
      req_in_l = '0;
      tick();
      chk("t5_i2_valid", 64'(out_valid_l), 64'd1);
      chk("t5_i2", 64'(out_idx_l), 64'd2);
      tick();
      chk("t5_i5", 64'(out_idx_l), 64'd5);
      chk("t5_i5_pending", 64'(pending_l), 64'h80);
      tick();
      chk("t5_i7", 64'(out_idx_l), 64'd7);
      chk("t5_i7_valid", 64'(out_valid_l), 64'd1);
      tick();
      chk("t5_empty", 64'(out_valid_l), 64'd0);
      chk("t5_overflow", 64'(overflow_l), 64'd0);

      // 6: async reset mid-burst with pending=0x50 and a held index
      out_ready = 1'b0;
      req_in = 8'h80;
      tick();
      req_in = 8'h50;
      tick();
      chk_main("t6_pre", 1'b1, 3'd7, 8'h50, 1'b0);
      req_in = '0;
      #1;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 64'(out_valid), 64'd0);
      chk("t6_async_idx", 64'(out_idx), 64'd0);
      chk("t6_async_pending", 64'(pending), 64'd0);
      chk("t6_async_overflow", 64'(overflow), 64'd0);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_main("t6_idle", 1'b0, 3'd0, 8'h00, 1'b0);
      end
      req_in = 8'h01;
      tick();
      chk_main("t6_new_cap", 1'b0, 3'd0, 8'h01, 1'b0);
      req_in = '0;
      tick();
      chk_main("t6_new_issue", 1'b1, 3'd0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
